// File: rtl/pin_in_sync_if.sv
// Pad-side pin bus: raw pad levels and filter enables in, conditioned levels and edge strobes out.
`timescale 1ns/1ps
interface pin_in_sync_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] pin_raw;
    logic [WIDTH-1:0] filter_en;
    logic [WIDTH-1:0] pin_sync;
    logic [WIDTH-1:0] pin_rise;
    logic [WIDTH-1:0] pin_fall;

    modport master (
        output pin_raw,
        output filter_en,
        input  pin_sync,
        input  pin_rise,
        input  pin_fall
    );

    modport slave (
        input  pin_raw,
        input  filter_en,
        output pin_sync,
        output pin_rise,
        output pin_fall
    );
endinterface

// File: rtl/pin_in_sync.sv
// Brings asynchronous pad levels into clock_160 through a flop chain, with optional
// per-pin persistence filter and registered one-cycle rise/fall strobes.
`timescale 1ns/1ps
module pin_in_sync #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic        clock_160,
    input  logic        res,
    pin_in_sync_if.slave bus
);
    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_pin_sync;
    logic [WIDTH-1:0] r_pin_rise;
    logic [WIDTH-1:0] r_pin_fall;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_next_sync;
    logic [CW-1:0]    w_next_cnt [WIDTH];

    assign w_s = r_sync[SYNC_STAGES-1];

    // A mismatch must persist FILTER_CYCLES consecutive cycles; any matching cycle clears the count.
    always_comb begin
        w_next_sync = r_pin_sync;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_next_cnt[i] = '0;
            if (!bus.filter_en[i]) begin
                w_next_sync[i] = w_s[i];
            end else if (w_s[i] != r_pin_sync[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_next_sync[i] = w_s[i];
                end else begin
                    w_next_cnt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= {WIDTH{RESET_LEVEL}};
            end
            r_pin_sync <= {WIDTH{RESET_LEVEL}};
            r_pin_rise <= '0;
            r_pin_fall <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.pin_raw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_pin_sync <= w_next_sync;
            r_pin_rise <= w_next_sync & ~r_pin_sync;
            r_pin_fall <= ~w_next_sync & r_pin_sync;
            r_cnt      <= w_next_cnt;
        end
    end

    assign bus.pin_sync = r_pin_sync;
    assign bus.pin_rise = r_pin_rise;
    assign bus.pin_fall = r_pin_fall;
endmodule

// File: doc/pin_in_sync.md
# pin_in_sync

Input-side conditioning for the P1V I/O ring. It brings the 32 asynchronous external pin levels into the `clock_160` domain through a multi-stage synchronizer, with an optional per-pin glitch filter. It also produces one-cycle rise and fall strobes. It sits between the board `pin` pads and the `pin_in` bus of the core, complementing the output/direction drive path.

## Interface

Parameters:
- `WIDTH`, 32: number of pins handled.
- `SYNC_STAGES`, 2: synchronizer flops per pin; must be ≥ 2.
- `FILTER_CYCLES`, 4: consecutive cycles a changed level must persist before it is accepted; must be ≥ 1. A value of 1 is equivalent to no filtering.
- `RESET_LEVEL`, 1'b0: value loaded into every synchronizer flop and into `pin_sync` on reset.

Ports:
- `clock_160`, input, 1: sole clock, 160 MHz.
- `res`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `pin_raw`, input, `WIDTH`: asynchronous pad levels.
- `filter_en`, input, `WIDTH`: per-pin filter enable, synchronous to `clock_160`.
- `pin_sync`, output, `WIDTH`: conditioned, registered pin levels, fed to the core `pin_in`.
- `pin_rise`, output, `WIDTH`: one-cycle strobe when `pin_sync[i]` changes 0→1.
- `pin_fall`, output, `WIDTH`: one-cycle strobe when `pin_sync[i]` changes 1→0.

## Operation

- Per pin `i`, a chain of `SYNC_STAGES` flops samples `pin_raw[i]`. The last stage is `s[i]`. No logic is allowed between chain flops.
- Unfiltered path (`filter_en[i]`=0): `pin_sync[i]` <= `s[i]` every cycle, and `cnt[i]` <= 0.
- Filtered path (`filter_en[i]`=1), with per-pin counter `cnt[i]` of width $clog2(FILTER_CYCLES+1):
  - `s[i]` == `pin_sync[i]`: `cnt[i]` <= 0.
  - `s[i]` != `pin_sync[i]` and `cnt[i]` == FILTER_CYCLES-1: `pin_sync[i]` <= `s[i]` and `cnt[i]` <= 0.
  - `s[i]` != `pin_sync[i]` otherwise: `cnt[i]` <= `cnt[i]`+1.
- Any single cycle where `s[i]` returns to `pin_sync[i]` discards the partial count. Pulses shorter than `FILTER_CYCLES` cycles at `s[i]` never reach `pin_sync`.
- Edge strobes are registered and asserted in the same cycle that `pin_sync[i]` takes its new value:
  - `pin_rise[i]` <= (next `pin_sync[i]`=1 and current `pin_sync[i]`=0).
  - `pin_fall[i]` is the mirror image.
  - At most one of the two strobes is high per pin per cycle, and each lasts exactly one cycle.
- `filter_en[i]` falling mid-count: the count is cleared and `pin_sync[i]` follows `s[i]` at the next edge, with the strobe generated normally.
- `filter_en[i]` rising: counting starts from 0 at the next mismatch.
- Pins are fully independent. There is no cross-pin state.

## Timing

- Reset (asynchronous assert, held while `res`=1):
  - All synchronizer flops and `pin_sync` = `RESET_LEVEL`.
  - `cnt` = 0.
  - `pin_rise` = `pin_fall` = 0.
- First edge after `res` deasserts: normal operation. No strobe is generated for a reset-level mismatch until the mismatch propagates through the normal path.
- Reset mid-count or mid-synchronization: all state is discarded, with no stale strobe after release.
- Latency from a `pin_raw` change meeting setup before edge 1:
  - Unfiltered: `pin_sync` updates at edge `SYNC_STAGES`+1 (3 with defaults).
  - Filtered: `pin_sync` updates at edge `SYNC_STAGES`+`FILTER_CYCLES` (6 with defaults).
  - Strobes follow the same latency.
- Metastability: an edge arriving at the sample point may be resolved one cycle late. Latency uncertainty is +1 cycle and no other effect is allowed.
- Minimum accepted pulse width at `pin_raw` with the filter enabled: `FILTER_CYCLES` cycles.

## Test plan

- Reset, with `RESET_LEVEL`=0 and `pin_raw`=32'hFFFFFFFF held, `filter_en`=0: during `res` all outputs are 0. After release, `pin_sync`=FFFFFFFF at the 3rd edge, with `pin_rise`=FFFFFFFF for exactly that one cycle.
- Unfiltered pin 5 toggles 0→1→0 with a 1-cycle high: `pin_sync[5]` is high for 1 cycle, 3 edges after the rise. `pin_rise[5]` and `pin_fall[5]` each pulse once, on consecutive cycles.
- Filtered pin 0 (`FILTER_CYCLES`=4) with a 3-cycle high pulse: `pin_sync[0]` stays 0 and no strobes occur. A 4-cycle pulse gives `pin_sync[0]`=1 at edge 6 after the rise, held for 4 cycles, with one rise strobe and one fall strobe.
- Filtered pin 31, input high for 2 cycles, low for 1 cycle, then high steadily: the count restarts, and `pin_sync[31]` rises 4 cycles after the final stable high reaches `s`.
- Pin 7 filtered with `cnt`=2 mid-count, then `filter_en[7]` dropped: `pin_sync[7]` takes `s[7]` at the next edge with one strobe, and `cnt` reads 0.
- `res` asserted asynchronously while pins 0–15 are mid-filter: all outputs are 0 immediately, and no strobe appears in the first 2 cycles after release with `pin_raw`=0.
